// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks a latched truth table and streams SOP minterm / POS maxterm indices
module truth_table_scanner #(
    parameter int N = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [(1<<N)-1:0]   table_in,
    input  logic                term_ready,
    output logic                busy,
    output logic                term_valid,
    output logic [N-1:0]        term_index,
    output logic                done,
    output logic [N:0]          term_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

    logic [1:0]          state;
    logic [(1<<N)-1:0]   tbl;
    logic                md;
    logic [N-1:0]        idx;
    logic                tgt;

    // SOP hunts for ones, POS for zeros
    assign tgt  = ~md;
    assign busy = (state == S_SCAN) || (state == S_EMIT);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tbl        <= '0;
            md         <= 1'b0;
            idx        <= '0;
            term_valid <= 1'b0;
            term_index <= '0;
            term_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tbl        <= table_in;
                        md         <= mode;
                        idx        <= '0;
                        term_count <= '0;
                        state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (tbl[idx] == tgt) begin
                        term_valid <= 1'b1;
                        term_index <= idx;
                        term_count <= term_count + 1'b1;
                        state      <= S_EMIT;
                    end else if (idx == IDX_LAST) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_EMIT: begin
                    // last index always leaves through DONE so idx never wraps
                    if (term_ready) begin
                        term_valid <= 1'b0;
                        if (idx == IDX_LAST) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - directed and random checks of truth_table_scanner against a set-based model
module tb_truth_table_scanner;

    logic       clk;
    logic       reset;
    logic       mode;
    logic       term_ready;
    logic       start2, start3;
    logic [3:0] tbl2;
    logic [7:0] tbl3;
    logic       busy2, valid2, done2;
    logic [1:0] index2;
    logic [2:0] count2;
    logic       busy3, valid3, done3;
    logic [2:0] index3;
    logic [3:0] count3;
    logic       sel;

    logic [31:0] o_busy, o_valid, o_index, o_done, o_count;

    int n_assert = 0;
    int n_fail   = 0;

    truth_table_scanner #(.N(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .start      (start2),
        .mode       (mode),
        .table_in   (tbl2),
        .term_ready (term_ready),
        .busy       (busy2),
        .term_valid (valid2),
        .term_index (index2),
        .done       (done2),
        .term_count (count2)
    );

    truth_table_scanner #(.N(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .start      (start3),
        .mode       (mode),
        .table_in   (tbl3),
        .term_ready (term_ready),
        .busy       (busy3),
        .term_valid (valid3),
        .term_index (index3),
        .done       (done3),
        .term_count (count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_busy  = sel ? {31'b0, busy3}  : {31'b0, busy2};
        o_valid = sel ? {31'b0, valid3} : {31'b0, valid2};
        o_done  = sel ? {31'b0, done3}  : {31'b0, done2};
        o_index = sel ? {29'b0, index3} : {30'b0, index2};
        o_count = sel ? {28'b0, count3} : {29'b0, count2};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  o_busy,  32'd0);
        check({tag, "_valid"}, o_valid, 32'd0);
        check({tag, "_index"}, o_index, 32'd0);
        check({tag, "_done"},  o_done,  32'd0);
        check({tag, "_count"}, o_count, 32'd0);
    endtask

    // Model: the expected stream is simply the set of indices whose table bit equals ~mode,
    // in ascending order; each index costs one cycle, each term one more plus its stalls.
    task automatic run_scan(input bit s, input logic [7:0] t, input logic m,
                            input int stall, input bit perturb);
        int q[$];
        int w, k, c, emitted, stall_left;
        bit in_term, got_done;
        w = s ? 8 : 4;
        for (int i = 0; i < w; i++)
            if (t[i] == ~m) q.push_back(i);
        k = q.size();
        sel = s;
        @(negedge clk);
        if (s) begin tbl3 = t; start3 = 1'b1; end
        else   begin tbl2 = t[3:0]; start2 = 1'b1; end
        mode = m;
        @(negedge clk);
        start2 = 1'b0;
        start3 = 1'b0;
        check("busy_after_start", o_busy, 32'd1);
        c = 0; emitted = 0; in_term = 1'b0; got_done = 1'b0; stall_left = 0;
        while (!got_done && c < 300) begin
            if (perturb && c == 2) begin
                if (s) begin start3 = 1'b1; tbl3 = ~tbl3; end
                else   begin start2 = 1'b1; tbl2 = ~tbl2; end
                mode = ~mode;
            end else if (perturb && c == 3) begin
                start2 = 1'b0;
                start3 = 1'b0;
            end
            if (o_done[0]) begin
                got_done = 1'b1;
                check("done_latency", 32'(c), 32'(w + k * (1 + stall)));
                check("done_count", o_count, 32'(k));
                check("done_missing_terms", 32'(q.size()), 32'd0);
                check("done_valid_low", o_valid, 32'd0);
            end else begin
                check("busy_scan", o_busy, 32'd1);
                if (o_valid[0]) begin
                    if (q.size() == 0) begin
                        check("extra_term", o_index, 32'hFFFF_FFFF);
                        term_ready = 1'b1;
                    end else begin
                        if (!in_term) begin
                            in_term = 1'b1;
                            stall_left = stall;
                            check("term_index", o_index, 32'(q[0]));
                            check("term_count_live", o_count, 32'(emitted + 1));
                        end else begin
                            check("term_index_stable", o_index, 32'(q[0]));
                        end
                        if (stall_left > 0) begin
                            term_ready = 1'b0;
                            stall_left--;
                        end else begin
                            term_ready = 1'b1;
                            void'(q.pop_front());
                            emitted++;
                            in_term = 1'b0;
                        end
                    end
                end else begin
                    term_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                c++;
            end
        end
        if (!got_done) check("done_timeout", 32'd0, 32'd1);
        term_ready = 1'b1;
        @(negedge clk);
        check("done_one_cycle", o_done, 32'd0);
        check("idle_after_done", o_busy, 32'd0);
        check("count_held", o_count, 32'(k));
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; term_ready = 1'b1;
        start2 = 1'b0; start3 = 1'b0; tbl2 = '0; tbl3 = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sel = 1'b0; check_idle_zero("reset_n2");
        sel = 1'b1; check_idle_zero("reset_n3");
        reset = 1'b0;
        sel = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_idle_zero("idle_n2");
        end

        run_scan(1'b0, 8'h02, 1'b0, 0, 1'b0);
        run_scan(1'b0, 8'h02, 1'b1, 3, 1'b0);
        run_scan(1'b1, 8'h00, 1'b0, 0, 1'b0);
        run_scan(1'b1, 8'hFF, 1'b0, 0, 1'b0);
        run_scan(1'b1, 8'hA5, 1'b0, 1, 1'b1);
        run_scan(1'b0, 8'h06, 1'b1, 0, 1'b1);

        // abort from EMIT: index 0 of an all-ones table stalls there
        sel = 1'b1;
        @(negedge clk);
        tbl3 = 8'hFF; mode = 1'b0; start3 = 1'b1; term_ready = 1'b0;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 5 && !o_valid[0]; i++) @(negedge clk);
        check("reach_emit", o_valid, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        term_ready = 1'b1;
        check_idle_zero("mid_reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_abort", o_done, 32'd0);
        end
        run_scan(1'b1, 8'h3C, 1'b1, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            run_scan(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
